// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// my_pkg -- shared types and constants for the program loader.
//   loader_cmd_e   : header command field encoding
//   loader_state_e : loader FSM states (CHECK only exists when the
//                    PROG_LOADER_CHECKSUM_EN macro is defined)
//   LOADER_ADDR_W  : memory write-port address width
//   LOADER_MAX_COUNT : largest legal payload word count in one header
// -----------------------------------------------------------------------------
package my_pkg;

    localparam int LOADER_ADDR_W    = 10;
    localparam int LOADER_MAX_COUNT = 1024;
    localparam int LOADER_CNT_W     = 11;   // header count field width
    localparam int LOADER_DATA_W    = 32;

    typedef enum logic [1:0] {
        CMD_LOAD_PROG = 2'b00,
        CMD_LOAD_DATA = 2'b01,
        CMD_RUN       = 2'b10,
        CMD_RSVD      = 2'b11
    } loader_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHECK = 2'd3,
`endif
        ST_RUN   = 2'd2
    } loader_state_e;

endpackage

// File: rtl/prog_loader_if.sv
// -----------------------------------------------------------------------------
// prog_loader_if -- host word stream into the program loader.
//   in_valid : host word valid            (master -> slave)
//   in_data  : header/payload/checksum    (master -> slave)
//   in_ready : loader accepts the word    (slave -> master)
//   A word transfers on a rising edge where in_valid & in_ready.
// -----------------------------------------------------------------------------
interface prog_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader -- streams a program and data image from a host into the core's
// instruction and data memories, then releases the core.
//
// Header word: [31:30] cmd, [25:16] base address, [10:0] word count.
// LOAD_PROG / LOAD_DATA headers are followed by <count> payload words, each
// written to consecutive (mod 1024) addresses one cycle after acceptance.
// A RUN header raises START (only if no error has been seen) and the loader
// stops accepting words until reset.
//
// Optional feature (macro PROG_LOADER_CHECKSUM_EN): each load is followed by
// one checksum word (32-bit sum of the payload); a mismatch sets err.
//
// Ports:
//   CLK, RSTn              clock, asynchronous active-low reset
//   host                   host word stream (prog_loader_if.slave)
//   TB_LOAD_PROGRAM_*      instruction-memory write port (CTRL/ADDR/DATA)
//   TB_LOAD_DATA_*         data-memory write port (CTRL/ADDR/DATA)
//   START                  core run enable, sticky until reset
//   busy                   high while a load (or checksum) is in progress
//   err                    sticky protocol / checksum error
// All outputs are registered.
// -----------------------------------------------------------------------------
module prog_loader
    import my_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RSTn,
    prog_loader_if.slave             host,
    output logic                     TB_LOAD_PROGRAM_CTRL,
    output logic [LOADER_ADDR_W-1:0] TB_LOAD_PROGRAM_ADDR,
    output logic [LOADER_DATA_W-1:0] TB_LOAD_PROGRAM_DATA,
    output logic                     TB_LOAD_DATA_CTRL,
    output logic [LOADER_ADDR_W-1:0] TB_LOAD_DATA_ADDR,
    output logic [LOADER_DATA_W-1:0] TB_LOAD_DATA_DATA,
    output logic                     START,
    output logic                     busy,
    output logic                     err
);

    loader_state_e            state_q;
    logic                     rdy_q;
    logic [LOADER_ADDR_W-1:0] addr_q;
    logic [LOADER_CNT_W-1:0]  left_q;
    logic                     sel_data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [LOADER_DATA_W-1:0] sum_q;
`endif

    // Inline header decode
    loader_cmd_e              hdr_cmd;
    logic [LOADER_ADDR_W-1:0] hdr_base;
    logic [LOADER_CNT_W-1:0]  hdr_cnt;
    logic                     xfer;

    assign hdr_cmd  = loader_cmd_e'(host.in_data[31:30]);
    assign hdr_base = host.in_data[25:16];
    assign hdr_cnt  = host.in_data[10:0];

    // Handshake uses the registered ready, so nothing from in_valid reaches
    // an output combinationally.
    assign xfer          = host.in_valid & rdy_q;
    assign host.in_ready = rdy_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q              <= ST_IDLE;
            rdy_q                <= 1'b0;
            addr_q               <= '0;
            left_q               <= '0;
            sel_data_q           <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q                <= '0;
`endif
            TB_LOAD_PROGRAM_CTRL <= 1'b0;
            TB_LOAD_PROGRAM_ADDR <= '0;
            TB_LOAD_PROGRAM_DATA <= '0;
            TB_LOAD_DATA_CTRL    <= 1'b0;
            TB_LOAD_DATA_ADDR    <= '0;
            TB_LOAD_DATA_DATA    <= '0;
            START                <= 1'b0;
            busy                 <= 1'b0;
            err                  <= 1'b0;
        end else begin
            // Write strobes are single-cycle pulses; ADDR/DATA simply hold.
            TB_LOAD_PROGRAM_CTRL <= 1'b0;
            TB_LOAD_DATA_CTRL    <= 1'b0;
            // Ready comes up on the first edge out of reset and stays up
            // until a RUN header is taken.
            rdy_q                <= (state_q != ST_RUN);

            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        if (hdr_cmd == CMD_RSVD ||
                            hdr_cnt > LOADER_CNT_W'(LOADER_MAX_COUNT)) begin
                            err <= 1'b1;
                        end else if (hdr_cmd == CMD_RUN) begin
                            if (!err) begin
                                state_q <= ST_RUN;
                                START   <= 1'b1;
                                rdy_q   <= 1'b0;
                            end
                        end else if (hdr_cnt != '0) begin
                            state_q    <= ST_LOAD;
                            busy       <= 1'b1;
                            addr_q     <= hdr_base;
                            left_q     <= hdr_cnt;
                            sel_data_q <= (hdr_cmd == CMD_LOAD_DATA);
`ifdef PROG_LOADER_CHECKSUM_EN
                            sum_q      <= '0;
`endif
                        end
                    end
                end

                ST_LOAD: begin
                    if (xfer) begin
                        if (sel_data_q) begin
                            TB_LOAD_DATA_CTRL    <= 1'b1;
                            TB_LOAD_DATA_ADDR    <= addr_q;
                            TB_LOAD_DATA_DATA    <= host.in_data;
                        end else begin
                            TB_LOAD_PROGRAM_CTRL <= 1'b1;
                            TB_LOAD_PROGRAM_ADDR <= addr_q;
                            TB_LOAD_PROGRAM_DATA <= host.in_data;
                        end
                        // Natural 10-bit overflow gives the 0x3FF -> 0x000 wrap.
                        addr_q <= addr_q + LOADER_ADDR_W'(1);
                        left_q <= left_q - LOADER_CNT_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_q  <= sum_q + host.in_data;
                        if (left_q == LOADER_CNT_W'(1)) begin
                            state_q <= ST_CHECK;
                        end
`else
                        if (left_q == LOADER_CNT_W'(1)) begin
                            state_q <= ST_IDLE;
                            busy    <= 1'b0;
                        end
`endif
                    end
                end

`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    // Writes already issued stay in memory; only err records
                    // the bad image.
                    if (xfer) begin
                        if (host.in_data != sum_q) begin
                            err <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
`endif

                ST_RUN: begin
                    rdy_q <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader -- self-checking bench for prog_loader.
// A transaction-level model (header parse, payload index -> address, running
// payload sum) predicts every output one cycle ahead; outputs are compared on
// every falling edge. Directed scenarios plus randomized loads with random
// in_valid gaps. Honours PROG_LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_prog_loader;
    import my_pkg::*;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        p_ctrl, d_ctrl, START, busy, err;
    logic [9:0]  p_addr, d_addr;
    logic [31:0] p_data, d_data;

    always #5 CLK = ~CLK;

    prog_loader_if host();

    prog_loader dut (
        .CLK                  (CLK),
        .RSTn                 (RSTn),
        .host                 (host),
        .TB_LOAD_PROGRAM_CTRL (p_ctrl),
        .TB_LOAD_PROGRAM_ADDR (p_addr),
        .TB_LOAD_PROGRAM_DATA (p_data),
        .TB_LOAD_DATA_CTRL    (d_ctrl),
        .TB_LOAD_DATA_ADDR    (d_addr),
        .TB_LOAD_DATA_DATA    (d_data),
        .START                (START),
        .busy                 (busy),
        .err                  (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_LOAD = 1, M_CHECK = 2, M_RUN = 3;
    int          m_mode = M_IDLE;
    bit          m_rdy = 0, m_err = 0, m_start = 0, m_busy = 0, m_x;
    bit          e_p = 0, e_d = 0, ld_dat = 0;
    int          e_addr = 0, ld_base = 0, ld_n = 0, ld_k = 0;
    int          h_cmd, h_cnt, h_base;
    logic [31:0] e_data = 0, m_sum = 0, w;
    int          acc_cnt = 0;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            m_mode = M_IDLE; m_rdy = 0; m_err = 0; m_start = 0; m_busy = 0;
            e_p = 0; e_d = 0; ld_k = 0; ld_n = 0;
        end else begin
            m_x = host.in_valid && m_rdy;
            e_p = 0; e_d = 0;
            if (m_x) begin
                acc_cnt++;
                w = host.in_data;
                case (m_mode)
                    M_IDLE: begin
                        h_cmd = int'(w[31:30]); h_base = int'(w[25:16]); h_cnt = int'(w[10:0]);
                        if (h_cmd == 3 || h_cnt > 1024) m_err = 1;
                        else if (h_cmd == 2) begin
                            if (!m_err) begin m_mode = M_RUN; m_start = 1; end
                        end else if (h_cnt > 0) begin
                            m_mode = M_LOAD; ld_base = h_base; ld_n = h_cnt; ld_k = 0;
                            ld_dat = (h_cmd == 1); m_sum = 0;
                        end
                    end
                    M_LOAD: begin
                        e_addr = (ld_base + ld_k) % 1024;
                        e_data = w;
                        if (ld_dat) e_d = 1; else e_p = 1;
                        m_sum += w;
                        ld_k++;
`ifdef PROG_LOADER_CHECKSUM_EN
                        if (ld_k == ld_n) m_mode = M_CHECK;
`else
                        if (ld_k == ld_n) m_mode = M_IDLE;
`endif
                    end
                    M_CHECK: begin
                        if (w != m_sum) m_err = 1;
                        m_mode = M_IDLE;
                    end
                    default: ;
                endcase
            end
            m_rdy  = (m_mode != M_RUN);
            m_busy = (m_mode == M_LOAD || m_mode == M_CHECK);
        end
    end

    // ---------------- monitor ----------------
    int         pcnt = 0, dcnt = 0;
    logic [9:0]  cap_pa[$], cap_da[$];
    logic [31:0] cap_pd[$];

    always @(negedge CLK) begin
        chk("in_ready", 32'(host.in_ready), 32'(m_rdy));
        chk("START",    32'(START),         32'(m_start));
        chk("busy",     32'(busy),          32'(m_busy));
        chk("err",      32'(err),           32'(m_err));
        chk("p_ctrl",   32'(p_ctrl),        32'(e_p));
        chk("d_ctrl",   32'(d_ctrl),        32'(e_d));
        if (e_p) begin
            chk("p_addr", 32'(p_addr), 32'(e_addr));
            chk("p_data", p_data, e_data);
        end
        if (e_d) begin
            chk("d_addr", 32'(d_addr), 32'(e_addr));
            chk("d_data", d_data, e_data);
        end
        if (p_ctrl) begin pcnt++; cap_pa.push_back(p_addr); cap_pd.push_back(p_data); end
        if (d_ctrl) begin dcnt++; cap_da.push_back(d_addr); end
    end

    // ---------------- driver ----------------
    logic [31:0] pl[$];

    function automatic logic [31:0] hdr(input logic [1:0] c, input logic [9:0] b, input logic [10:0] n);
        return {c, 4'b0, b, 5'b0, n};
    endfunction

    task automatic idle(input int n);
        host.in_valid = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send(input logic [31:0] wd, input bit gap);
        int n0;
        if (gap) begin host.in_valid = 1'b0; @(negedge CLK); end
        n0 = acc_cnt;
        host.in_valid = 1'b1;
        host.in_data  = wd;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (acc_cnt != n0) break;
        end
        if (acc_cnt == n0) chk("accept_timeout", 32'(acc_cnt - n0), 32'd1);
        host.in_valid = 1'b0;
    endtask

    // gmode: 0 back-to-back, 1 gap before every payload word, 2 random gaps
    task automatic do_load(input logic [1:0] cmd, input logic [9:0] base, input int gmode, input bit bad);
        logic [31:0] s;
        bit g;
        s = '0;
        send(hdr(cmd, base, 11'(pl.size())), 1'b0);
        foreach (pl[i]) begin
            g = (gmode == 1) ? 1'b1 : (gmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            send(pl[i], g);
            s += pl[i];
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send(s + 32'(bad), 1'b0);
`else
        if (bad) s = '0;
`endif
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pctrl"}, 32'(p_ctrl), 0);   chk({tag, "_paddr"}, 32'(p_addr), 0);
        chk({tag, "_pdata"}, p_data, 0);        chk({tag, "_dctrl"}, 32'(d_ctrl), 0);
        chk({tag, "_daddr"}, 32'(d_addr), 0);   chk({tag, "_ddata"}, d_data, 0);
        chk({tag, "_start"}, 32'(START), 0);    chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_err"},   32'(err), 0);      chk({tag, "_rdy"}, 32'(host.in_ready), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK); #2 RSTn = 1'b0;
        @(negedge CLK);
        check_zero(tag);
        @(negedge CLK); #2 RSTn = 1'b1;
        @(negedge CLK);
    endtask

    logic [31:0] exp_w[3];
    logic [9:0]  exp_a[4];

    initial begin
        RSTn = 1'b1; host.in_valid = 1'b0; host.in_data = '0;
        #1 RSTn = 1'b0;
        repeat (3) @(negedge CLK);
        check_zero("rst0");
        #2 RSTn = 1'b1;
        @(negedge CLK);
        chk("rdy_after_rst", 32'(host.in_ready), 1);

        // Short program load at base 0
        pcnt = 0; dcnt = 0; cap_pa.delete(); cap_pd.delete();
        exp_w = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3};
        pl = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3};
        do_load(2'b00, 10'h000, 0, 1'b0);
        idle(3);
        chk("prog3_pulses", 32'(pcnt), 3);
        chk("prog3_dctrl", 32'(dcnt), 0);
        for (int i = 0; i < 3; i++) begin
            chk("prog3_addr", 32'(cap_pa[i]), 32'(i));
            chk("prog3_data", cap_pd[i], exp_w[i]);
        end

        // Data load across the top of the address space
        dcnt = 0; cap_da.delete();
        exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        pl = '{$urandom, $urandom, $urandom, $urandom};
        do_load(2'b01, 10'h3FE, 0, 1'b0);
        idle(3);
        chk("wrap_pulses", 32'(dcnt), 4);
        for (int i = 0; i < 4; i++) chk("wrap_addr", 32'(cap_da[i]), 32'(exp_a[i]));

        // in_valid toggling during a load
        dcnt = 0;
        pl = '{$urandom, $urandom, $urandom, $urandom};
        do_load(2'b01, 10'h040, 1, 1'b0);
        idle(3);
        chk("gap_pulses", 32'(dcnt), 4);

        // Count 0: no write, no error
        pcnt = 0; dcnt = 0;
        send(hdr(2'b00, 10'h005, 11'd0), 1'b0);
        idle(3);
        chk("cnt0_writes", 32'(pcnt + dcnt), 0);
        chk("cnt0_err", 32'(err), 0);

        // Randomized loads with random gaps
        for (int t = 0; t < 25; t++) begin
            pl.delete();
            for (int k = 0; k < int'($urandom_range(1, 7)); k++) pl.push_back($urandom);
            do_load(2'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 2, 1'b0);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        // Clean image (good checksum when enabled), then RUN
        pl = '{32'd1, 32'd2, 32'd3};
        do_load(2'b00, 10'h100, 0, 1'b0);
        idle(2);
        chk("good_err", 32'(err), 0);
        send(hdr(2'b10, 10'h0, 11'd0), 1'b0);
        idle(3);
        chk("run_start", 32'(START), 1);
        chk("run_rdy", 32'(host.in_ready), 0);
        chk("run_busy", 32'(busy), 0);

        // Reset in the middle of a load; the word on the bus is dropped
        do_reset("rst_run");
        pcnt = 0; cap_pa.delete();
        send(hdr(2'b00, 10'h020, 11'd5), 1'b0);
        send(32'hAAAA_0001, 1'b0);
        send(32'hAAAA_0002, 1'b0);
        idle(1);
        host.in_valid = 1'b1; host.in_data = 32'hDEAD_BEEF;
        do_reset("rst_mid");
        pcnt = 0; cap_pa.delete();
        pl = '{32'h1234_5678};
        do_load(2'b00, 10'h010, 0, 1'b0);
        idle(3);
        chk("rst_reload_pulses", 32'(pcnt), 1);
        chk("rst_reload_addr", 32'(cap_pa[0]), 32'h010);

        // Oversized count: error, no writes, RUN refused
        pcnt = 0; dcnt = 0;
        send(hdr(2'b00, 10'h000, 11'h7FF), 1'b0);
        idle(3);
        chk("big_err", 32'(err), 1);
        chk("big_writes", 32'(pcnt + dcnt), 0);
        send(hdr(2'b10, 10'h0, 11'd0), 1'b0);
        idle(3);
        chk("big_start", 32'(START), 0);
        chk("big_rdy", 32'(host.in_ready), 1);

        // Reserved command
        do_reset("rst_rsvd");
        send(hdr(2'b11, 10'h000, 11'd1), 1'b0);
        idle(2);
        chk("rsvd_err", 32'(err), 1);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Bad checksum: writes still happen, err set
        do_reset("rst_ck");
        pcnt = 0;
        pl = '{32'd1, 32'd2, 32'd3};
        do_load(2'b00, 10'h000, 0, 1'b1);
        idle(2);
        chk("ck_bad_err", 32'(err), 1);
        chk("ck_bad_pulses", 32'(pcnt), 3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL: CLK  input  1  single clock; all state on rising edge.
REQ-002 SHALL: RSTn  input  1  asynchronous, active-low reset.
REQ-003 SHALL: in_valid  input  1  host word valid.
REQ-004 SHALL: in_ready  output  1  loader accepts word; transfer = in_valid & in_ready.
REQ-005 SHALL: in_data  input  32  header, payload or checksum word.
REQ-006 SHALL: TB_LOAD_PROGRAM_CTRL / TB_LOAD_PROGRAM_ADDR / TB_LOAD_PROGRAM_DATA  output  1/10/32  instruction-memory write port.
REQ-007 SHALL: TB_LOAD_DATA_CTRL / TB_LOAD_DATA_ADDR / TB_LOAD_DATA_DATA  output  1/10/32  data-memory write port.
REQ-008 SHALL: START  output  1  core run enable.
REQ-009 SHALL: busy  output  1  high in any state except IDLE and RUN.
REQ-010 SHALL: err  output  1  sticky protocol/checksum error.

Function
REQ-011 SHALL: header fields: [31:30] cmd (00 LOAD_PROG, 01 LOAD_DATA, 10 RUN, 11 reserved); [25:16] base address; [10:0] count.
REQ-012 SHALL: states IDLE, LOAD, CHECK (checksum build only), RUN.
REQ-013 SHALL: IDLE: in_ready=1; a header is consumed per transfer.
REQ-014 SHALL: LOAD_PROG/LOAD_DATA with count 1..1024 -> LOAD, address counter = base, remaining = count.
REQ-015 SHALL: count 0 -> stay IDLE, no write; count >1024 or cmd 11 -> set err, stay IDLE.
REQ-016 SHALL: LOAD: in_ready=1; each transfer produces exactly one write pulse on the selected port in the next cycle (latency 1): CTRL=1, ADDR=current address, DATA=in_data.
REQ-017 SHALL: non-selected port CTRL stays 0; CTRL is 0 in every cycle without a preceding transfer (in_valid gaps insert idle cycles).
REQ-018 SHALL: address increments by 1 modulo 1024 after each payload word (0x3FF wraps to 0x000).
REQ-019 SHALL: after the last payload word -> IDLE (or CHECK when REQ-027 applies); back-to-back headers are accepted with no bubble.
REQ-020 SHALL: RUN header with err=0 -> RUN; START rises the cycle after the transfer and stays 1 until reset.
REQ-021 SHALL: RUN header with err=1 -> stay IDLE, START stays 0.
REQ-022 SHALL: RUN: in_ready=0 permanently; CTRL outputs 0.
REQ-023 SHALL: all outputs registered; no combinational path from in_valid or in_data to any output.

Reset
REQ-024 SHALL: RSTn low, at any time including mid-LOAD, forces IDLE, in_ready=0 during reset, all CTRL/ADDR/DATA=0, START=0, busy=0, err=0, counters=0.
REQ-025 SHALL: in_ready=1 from the first rising edge after RSTn deasserts; words in flight at reset are discarded.

Configuration
REQ-026 SHALL: macro PROG_LOADER_CHECKSUM_EN selects payload checksum.
REQ-027 SHALL: when defined: after the last payload word -> CHECK; one extra word = 32-bit sum mod 2^32 of the payload words; mismatch sets err; -> IDLE. The write pulses already issued are not retracted.
REQ-028 SHALL: when undefined: no CHECK state, no checksum word, no accumulator logic.

Structure
REQ-029 SHALL: my_pkg holds loader_cmd_e enum, loader_state_e enum, LOADER_ADDR_W=10, LOADER_MAX_COUNT=1024.
REQ-030 SHALL: single flat module with inline header decode; no sub-module.

Verification
REQ-031 SHALL: LOAD_PROG base 0x000 count 3, words 0x00500093, 0x00100113, 0x002081B3 -> three PROGRAM_CTRL pulses, ADDR 0,1,2, matching DATA; DATA_CTRL never high.
REQ-032 SHALL: LOAD_DATA base 0x3FE count 4 -> DATA_ADDR sequence 0x3FE,0x3FF,0x000,0x001.
REQ-033 SHALL: in_valid toggled 1/0 during a count-4 load -> exactly 4 pulses, each one cycle after its transfer.
REQ-034 SHALL: header count 0x7FF -> err=1, no writes; following RUN header -> START stays 0.
REQ-035 SHALL: RSTn pulsed after 2 of 5 payload words -> all outputs 0; a new load of count 1 at base 0x010 writes address 0x010.
REQ-036 SHALL: with PROG_LOADER_CHECKSUM_EN, payload 1,2,3 + checksum 6 -> err=0, then RUN -> START=1; checksum 7 -> err=1.
